// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared constants and helpers for the data memory responder
//
// Purpose : FSM state encoding, word-index width helper and default
//           self-check addresses/data shared by the responder and monitor.
// Ports   : none (package).

package mem_pkg;

    // Responder FSM encoding
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    // Default self-check store: writing DEF_PASS_DATA to DEF_PASS_ADDR passes,
    // writes to DEF_IGNORE_ADDR never produce a verdict.
    localparam logic [31:0] DEF_PASS_ADDR   = 32'd84;
    localparam logic [31:0] DEF_PASS_DATA   = 32'd7;
    localparam logic [31:0] DEF_IGNORE_ADDR = 32'd80;

    // Ceiling log2, never less than 1 so a single-word memory still has an index bit.
    function automatic int clog2(input int value);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/store_monitor.sv
// rtl/store_monitor.sv - sticky pass/fail verdict from committed CPU stores
//
// Purpose : Watches committed, error-free writes. The first write that is not
//           to the ignore address decides the verdict: the pass store
//           (PASS_DATA to PASS_ADDR) passes, anything else fails. The verdict
//           then sticks until reset.
// Ports   : i_clk     - rising-edge clock
//           i_rst_n   - asynchronous active-low reset, clears the verdict
//           i_commit  - one-cycle strobe: a valid write commits this edge
//           i_addr    - byte address of the committing write
//           i_data    - data of the committing write
//           o_done    - a verdict has been reached
//           o_pass    - the verdict is success (meaningful when o_done=1)

module store_monitor
    import mem_pkg::*;
#(
    parameter logic [31:0] PASS_ADDR   = DEF_PASS_ADDR,
    parameter logic [31:0] PASS_DATA   = DEF_PASS_DATA,
    parameter logic [31:0] IGNORE_ADDR = DEF_IGNORE_ADDR
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_commit,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_data,
    output logic        o_done,
    output logic        o_pass
);

    logic r_done;
    logic r_pass;
    logic w_is_pass;
    logic w_is_ignored;

    assign w_is_pass    = (i_addr == PASS_ADDR) && (i_data == PASS_DATA);
    assign w_is_ignored = (i_addr == IGNORE_ADDR);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_done <= 1'b0;
            r_pass <= 1'b0;
        end else if (i_commit && !r_done) begin
            // PASS_ADDR with wrong data falls through to the fail branch.
            if (w_is_pass) begin
                r_done <= 1'b1;
                r_pass <= 1'b1;
            end else if (!w_is_ignored) begin
                r_done <= 1'b1;
                r_pass <= 1'b0;
            end
        end
    end

    assign o_done = r_done;
    assign o_pass = r_pass;

endmodule

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - word data memory with valid/ready request and one-shot response
//
// Purpose : Serves the CPU data port. A request is accepted in IDLE, optionally
//           delayed by WAIT_STATES cycles, then answered with a single-cycle
//           resp_valid strobe. The array write and the read into resp_rdata
//           both happen on the edge that enters RESP. A store monitor turns
//           committed writes into a sticky pass/fail verdict.
// Ports   : clka       - rising-edge clock
//           rst        - asynchronous active-low reset
//           req_valid  - CPU presents a request
//           req_ready  - responder can accept (IDLE and out of reset)
//           req_we     - 1 = write, 0 = read
//           req_addr   - byte address
//           req_wdata  - store data
//           resp_valid - single-cycle response strobe
//           resp_rdata - read data, 0 on writes and errors
//           resp_err   - misaligned or out-of-range access
//           done       - sticky: a verdict has been reached
//           pass       - sticky: the verdict is success

module data_mem_responder
    import mem_pkg::*;
#(
    parameter int          DEPTH       = 64,
    parameter int          WAIT_STATES = 0,
    parameter logic [31:0] PASS_ADDR   = DEF_PASS_ADDR,
    parameter logic [31:0] PASS_DATA   = DEF_PASS_DATA,
    parameter logic [31:0] IGNORE_ADDR = DEF_IGNORE_ADDR
) (
    input  logic        clka,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        done,
    output logic        pass
);

    localparam int         IDX_W     = clog2(DEPTH);
    localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
    localparam logic       NO_WAIT   = (WAIT_STATES == 0);

    logic [1:0]       r_state;
    logic [3:0]       r_wait_cnt;
    logic             r_we;
    logic [31:0]      r_addr;
    logic [31:0]      r_wdata;
    logic [31:0]      r_rdata;
    logic             r_err;
    logic [31:0]      r_mem [DEPTH];

    logic             w_c_we;
    logic [31:0]      w_c_addr;
    logic [31:0]      w_c_wdata;
    logic             w_addr_err;
    logic [IDX_W-1:0] w_idx;
    logic             w_commit;
    logic             w_mem_write;

    // With no wait states the commit edge is the accept edge itself, so the
    // live request is used; otherwise the latched copy is committed.
    assign w_c_we    = (r_state == IDLE) ? req_we    : r_we;
    assign w_c_addr  = (r_state == IDLE) ? req_addr  : r_addr;
    assign w_c_wdata = (r_state == IDLE) ? req_wdata : r_wdata;

    assign w_addr_err = (w_c_addr[1:0] != 2'b00) || (w_c_addr[31:2] >= 30'(DEPTH));
    assign w_idx      = w_c_addr[IDX_W+1:2];

    // Edge that enters RESP.
    assign w_commit = ((r_state == IDLE) && req_valid && NO_WAIT) ||
                      ((r_state == WAIT) && (r_wait_cnt == 4'd0));

    assign w_mem_write = w_commit && w_c_we && !w_addr_err;

    always_ff @(posedge clka or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_wait_cnt <= 4'd0;
            r_we       <= 1'b0;
            r_addr     <= 32'd0;
            r_wdata    <= 32'd0;
            r_rdata    <= 32'd0;
            r_err      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_we    <= req_we;
                        r_addr  <= req_addr;
                        r_wdata <= req_wdata;
                        if (NO_WAIT) begin
                            r_state <= RESP;
                        end else begin
                            r_state    <= WAIT;
                            r_wait_cnt <= WAIT_LOAD;
                        end
                    end
                end
                WAIT: begin
                    if (r_wait_cnt == 4'd0) begin
                        r_state <= RESP;
                    end else begin
                        r_wait_cnt <= r_wait_cnt - 4'd1;
                    end
                end
                RESP: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase

            // Response data is captured once per transaction and then held.
            if (w_commit) begin
                r_err <= w_addr_err;
                if (w_addr_err || w_c_we) begin
                    r_rdata <= 32'd0;
                end else begin
                    r_rdata <= r_mem[w_idx];
                end
            end
        end
    end

    // Memory contents survive reset.
    always_ff @(posedge clka) begin
        if (w_mem_write) begin
            r_mem[w_idx] <= w_c_wdata;
        end
    end

    store_monitor #(
        .PASS_ADDR   (PASS_ADDR),
        .PASS_DATA   (PASS_DATA),
        .IGNORE_ADDR (IGNORE_ADDR)
    ) u_store_monitor (
        .i_clk    (clka),
        .i_rst_n  (rst),
        .i_commit (w_mem_write),
        .i_addr   (w_c_addr),
        .i_data   (w_c_wdata),
        .o_done   (done),
        .o_pass   (pass)
    );

    // Held low while rst is asserted even though the state already reads IDLE.
    assign req_ready  = rst && (r_state == IDLE);
    assign resp_valid = (r_state == RESP);
    assign resp_rdata = r_rdata;
    assign resp_err   = r_err;

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - self-checking bench for data_mem_responder

module tb_data_mem_responder;

    logic        clk;
    logic        rst0;
    logic        rst3;
    logic        sel;
    logic        req_valid;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    logic        rdy0, rv0, err0, done0, pass0;
    logic [31:0] rdata0;
    logic        rdy3, rv3, err3, done3, pass3;
    logic [31:0] rdata3;

    logic        m_ready, m_rv, m_err, m_done, m_pass;
    logic [31:0] m_rdata;

    int n_pass;
    int n_total;

    data_mem_responder #(.DEPTH(64), .WAIT_STATES(0)) u_dut0 (
        .clka       (clk),
        .rst        (rst0),
        .req_valid  (req_valid && !sel),
        .req_ready  (rdy0),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (rv0),
        .resp_rdata (rdata0),
        .resp_err   (err0),
        .done       (done0),
        .pass       (pass0)
    );

    data_mem_responder #(.DEPTH(64), .WAIT_STATES(3)) u_dut3 (
        .clka       (clk),
        .rst        (rst3),
        .req_valid  (req_valid && sel),
        .req_ready  (rdy3),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (rv3),
        .resp_rdata (rdata3),
        .resp_err   (err3),
        .done       (done3),
        .pass       (pass3)
    );

    assign m_ready = sel ? rdy3   : rdy0;
    assign m_rv    = sel ? rv3    : rv0;
    assign m_rdata = sel ? rdata3 : rdata0;
    assign m_err   = sel ? err3   : err0;
    assign m_done  = sel ? done3  : done0;
    assign m_pass  = sel ? pass3  : pass0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst_before;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic        exp_done;
        logic        exp_pass;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic pulse_reset(input logic which);
        @(negedge clk);
        if (which) rst3 = 1'b0; else rst0 = 1'b0;
        repeat (2) @(negedge clk);
        if (which) rst3 = 1'b1; else rst0 = 1'b1;
    endtask

    // Full handshake on the selected DUT; lat counts cycles from accept edge
    // to the cycle where resp_valid is seen.
    task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic err,
                          output logic dn, output logic ps,
                          output int lat, output logic one_shot);
        int guard;
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        guard = 0;
        while (!m_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!m_rv && lat < 40);
        rdata = m_rdata;
        err   = m_err;
        dn    = m_done;
        ps    = m_pass;
        @(negedge clk);
        one_shot = !m_rv;
    endtask

    initial begin
        logic [31:0] rdata;
        logic        err, dn, ps, one_shot;
        int          lat;

        n_pass    = 0;
        n_total   = 0;
        sel       = 1'b0;
        rst0      = 1'b0;
        rst3      = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = 32'd0;
        req_wdata = 32'd0;

        //                 rst we  addr       wdata          rdata          err  done pass
        vecs[0]  = '{1'b1, 1'b1, 32'd8,   32'h12345678, 32'h0,        1'b0, 1'b1, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 32'd8,   32'h0,        32'h12345678, 1'b0, 1'b1, 1'b0};
        vecs[2]  = '{1'b1, 1'b1, 32'd80,  32'd5,        32'h0,        1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 32'd84,  32'd7,        32'h0,        1'b0, 1'b1, 1'b1};
        vecs[4]  = '{1'b0, 1'b1, 32'd4,   32'd0,        32'h0,        1'b0, 1'b1, 1'b1};
        vecs[5]  = '{1'b1, 1'b1, 32'd84,  32'd9,        32'h0,        1'b0, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 32'd84,  32'd7,        32'h0,        1'b0, 1'b1, 1'b0};
        vecs[7]  = '{1'b1, 1'b1, 32'd4,   32'hCAFE0004, 32'h0,        1'b0, 1'b1, 1'b0};
        vecs[8]  = '{1'b1, 1'b1, 32'd6,   32'hDEADBEEF, 32'h0,        1'b1, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 32'd256, 32'hDEADBEEF, 32'h0,        1'b1, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 32'd4,   32'h0,        32'hCAFE0004, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 32'd2,   32'h0,        32'h0,        1'b1, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 1'b0, 32'd84,  32'h0,        32'd7,        1'b0, 1'b0, 1'b0};
        vecs[13] = '{1'b0, 1'b1, 32'd80,  32'h11,       32'h0,        1'b0, 1'b0, 1'b0};
        vecs[14] = '{1'b0, 1'b0, 32'd80,  32'h0,        32'h11,       1'b0, 1'b0, 1'b0};

        // Reset state of the zero-wait instance
        repeat (2) @(negedge clk);
        check("rst_ready_low", 32'(m_ready), 32'd0);
        check("rst_resp_valid", 32'(m_rv), 32'd0);
        check("rst_rdata", m_rdata, 32'd0);
        check("rst_err", 32'(m_err), 32'd0);
        check("rst_done", 32'(m_done), 32'd0);
        check("rst_pass", 32'(m_pass), 32'd0);
        rst0 = 1'b1;
        rst3 = 1'b1;
        #1 check("rst_release_ready", 32'(m_ready), 32'd1);

        // Table-driven vectors, zero wait states
        for (int i = 0; i < 15; i++) begin
            if (vecs[i].rst_before) pulse_reset(1'b0);
            do_req(vecs[i].we, vecs[i].addr, vecs[i].wdata, rdata, err, dn, ps, lat, one_shot);
            check($sformatf("v%0d_rdata", i), rdata, vecs[i].exp_rdata);
            check($sformatf("v%0d_err", i), 32'(err), 32'(vecs[i].exp_err));
            check($sformatf("v%0d_done", i), 32'(dn), 32'(vecs[i].exp_done));
            check($sformatf("v%0d_pass", i), 32'(ps), 32'(vecs[i].exp_pass));
            check($sformatf("v%0d_latency", i), 32'(lat), 32'd1);
            check($sformatf("v%0d_one_shot", i), 32'(one_shot), 32'd1);
        end

        // Three wait states
        sel = 1'b1;
        pulse_reset(1'b1);
        do_req(1'b1, 32'd12, 32'h55, rdata, err, dn, ps, lat, one_shot);
        check("w3_write_latency", 32'(lat), 32'd4);
        check("w3_write_err", 32'(err), 32'd0);
        check("w3_write_one_shot", 32'(one_shot), 32'd1);

        // Read with a write pulse during WAIT that must be ignored
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 32'd12;
        check("w3_ready_before", 32'(m_ready), 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            check($sformatf("w3_c%0d_ready", c), 32'(m_ready), (c >= 5) ? 32'd1 : 32'd0);
            check($sformatf("w3_c%0d_resp_valid", c), 32'(m_rv), (c == 4) ? 32'd1 : 32'd0);
            if (c == 4) check("w3_read_rdata", m_rdata, 32'h55);
            if (c == 2) begin
                req_valid = 1'b1;
                req_we    = 1'b1;
                req_addr  = 32'd12;
                req_wdata = 32'hBAD;
            end
            if (c == 3) req_valid = 1'b0;
        end
        do_req(1'b0, 32'd12, 32'h0, rdata, err, dn, ps, lat, one_shot);
        check("w3_pulse_ignored", rdata, 32'h55);
        check("w3_read_latency", 32'(lat), 32'd4);

        // Reset in the second WAIT cycle aborts the write of 0xAA
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'd12;
        req_wdata = 32'hAA;
        check("abort_ready_before", 32'(m_ready), 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        #2 rst3 = 1'b0;
        #1;
        check("abort_ready", 32'(m_ready), 32'd0);
        check("abort_resp_valid", 32'(m_rv), 32'd0);
        check("abort_rdata", m_rdata, 32'd0);
        check("abort_err", 32'(m_err), 32'd0);
        check("abort_done", 32'(m_done), 32'd0);
        check("abort_pass", 32'(m_pass), 32'd0);
        repeat (2) @(negedge clk);
        rst3 = 1'b1;
        #1 check("abort_release_ready", 32'(m_ready), 32'd1);
        do_req(1'b0, 32'd12, 32'h0, rdata, err, dn, ps, lat, one_shot);
        check("abort_readback", rdata, 32'h55);
        check("abort_readback_done", 32'(dn), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
